work_scheduler: RTL and testbench

- Sequences the double-SHA256 hashing pipeline.
- Accepts work (midstate + 96-bit data tail) from the comm block over a valid/ready handshake and sweeps the nonce range, one nonce per cycle.
- Tracks pipeline latency so every result is attributed to the correct nonce, stops cleanly at range exhaustion, and queues golden nonces for the comm block.
- Sits between the comm block and the two-stage hasher (sha256_pipe130 + sha256_pipe123).

---
 rtl/miner_pkg.sv | 26 ++
 rtl/work_scheduler_if.sv | 33 +++
 rtl/golden_fifo.sv | 60 ++++++
 rtl/work_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_work_scheduler.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/miner_pkg.sv
// -----------------------------------------------------------------------------
// miner_pkg
// Shared types and constants for the hashing work scheduler.
//   sched_state_t    : scheduler FSM encoding (IDLE / HASH / DRAIN)
//   MIDSTATE_W       : midstate width handed to the first hasher stage
//   DATA_W           : header tail width (the 96 bits after the midstate)
//   NONCE_W          : nonce / result word width
//   DEF_PIPE_LATENCY : nonce-to-result latency of the sha256_pipe130+123 pair
//   DEF_GOLDEN_MATCH : hash_tail value that marks a golden ticket
// -----------------------------------------------------------------------------
package miner_pkg;

  localparam int MIDSTATE_W = 256;
  localparam int DATA_W     = 96;
  localparam int NONCE_W    = 32;

  localparam int                 DEF_PIPE_LATENCY = 254;
  localparam logic [NONCE_W-1:0] DEF_GOLDEN_MATCH = 32'hA41F32E7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HASH  = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/work_scheduler_if.sv
// -----------------------------------------------------------------------------
// work_scheduler_if
// Bus between the comm block (master) and the work scheduler (slave).
//   work_valid/work_ready/work_midstate/work_data : new work, comm -> scheduler
//   gn_valid/gn_ready/gn_nonce                    : golden nonces, scheduler -> comm
//
// Handshake rule for both channels: a transfer happens on the rising clock edge
// where valid && ready are both high. The sender holds its payload stable while
// valid is high and ready is low; ready may be high with valid low.
// -----------------------------------------------------------------------------
interface work_scheduler_if;
  import miner_pkg::*;

  logic                  work_valid;
  logic                  work_ready;
  logic [MIDSTATE_W-1:0] work_midstate;
  logic [DATA_W-1:0]     work_data;

  logic                  gn_valid;
  logic                  gn_ready;
  logic [NONCE_W-1:0]    gn_nonce;

  modport master (
    output work_valid, work_midstate, work_data, gn_ready,
    input  work_ready, gn_valid, gn_nonce
  );

  modport slave (
    input  work_valid, work_midstate, work_data, gn_ready,
    output work_ready, gn_valid, gn_nonce
  );

endinterface

// File: rtl/golden_fifo.sv
// -----------------------------------------------------------------------------
// golden_fifo
// Small synchronous FIFO holding golden nonces for the comm block.
//   i_clk, i_rst_n : clock, synchronous active-low reset (empties the queue)
//   i_push, i_din  : write request and data; taken when not full, or when
//                    full and a pop happens in the same cycle
//   i_pop          : read request; ignored when empty
//   o_dout         : head entry, stable until popped
//   o_full/o_empty : occupancy flags
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module golden_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int           AW      = $clog2(DEPTH);
  localparam logic [AW:0]  PTR_ONE = (AW + 1)'(1);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the head slot this edge, so a full queue can still take a push.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/work_scheduler.sv
// -----------------------------------------------------------------------------
// work_scheduler
// Sequences the double-SHA256 hasher pair: takes work from the comm block,
// sweeps nonces 0..NONCE_LAST one per cycle, tracks the fixed hasher latency so
// each result is attributed to its nonce, and queues golden nonces.
//
// Ports
//   hash_clk, rst_n  : clock (rising edge), synchronous active-low reset
//   bus (slave)      : work_* handshake in, gn_* golden-nonce handshake out
//   pipe_midstate/pipe_data/pipe_nonce : operands to the hasher
//   hash_tail        : result word from the second hasher stage
//   busy             : state != IDLE
//   overflow         : sticky, a golden nonce was dropped on a full queue
//   hashes_done      : (WORK_SCHED_STATS_EN) saturating count of valid results
//   golden_count     : (WORK_SCHED_STATS_EN) wrapping count of queued goldens
//   o_dbg_state      : current FSM state
//
// Optional feature macro: WORK_SCHED_STATS_EN adds the two statistics outputs.
// -----------------------------------------------------------------------------
module work_scheduler
  import miner_pkg::*;
#(
  parameter int                 PIPE_LATENCY = DEF_PIPE_LATENCY,
  parameter logic [NONCE_W-1:0] GOLDEN_MATCH = DEF_GOLDEN_MATCH,
  parameter logic [NONCE_W-1:0] NONCE_LAST   = 32'hFFFFFFFF,
  parameter int                 FIFO_DEPTH   = 4
) (
  input  logic                  hash_clk,
  input  logic                  rst_n,
  work_scheduler_if.slave       bus,
  output logic [MIDSTATE_W-1:0] pipe_midstate,
  output logic [DATA_W-1:0]     pipe_data,
  output logic [NONCE_W-1:0]    pipe_nonce,
  input  logic [NONCE_W-1:0]    hash_tail,
  output logic                  busy,
  output logic                  overflow,
`ifdef WORK_SCHED_STATS_EN
  output logic [47:0]           hashes_done,
  output logic [15:0]           golden_count,
`endif
  output sched_state_t          o_dbg_state
);

  localparam int            CW         = $clog2(PIPE_LATENCY + 1);
  localparam logic [CW-1:0] WARM_MAX   = CW'(PIPE_LATENCY);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(PIPE_LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  sched_state_t          r_state;
  sched_state_t          w_next;
  logic [MIDSTATE_W-1:0] r_pipe_midstate;
  logic [DATA_W-1:0]     r_pipe_data;
  logic [NONCE_W-1:0]    r_pipe_nonce;
  logic [CW-1:0]         r_warm;
  logic [CW-1:0]         r_drain;
  logic [NONCE_W-1:0]    r_res_nonce;
  logic                  r_overflow;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_res_valid;
  logic                  w_busy;
  logic                  w_match;
  logic                  w_pop;
  logic                  w_push_ok;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [NONCE_W-1:0]    w_fifo_dout;

  // Work is accepted in every state, so ready only depends on reset.
  assign w_ready  = rst_n;
  assign w_accept = bus.work_valid && w_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge hash_clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = IDLE;
      HASH:    if (r_pipe_nonce == NONCE_LAST) w_next = DRAIN;
      DRAIN:   if (r_drain == DRAIN_LAST)      w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // New work restarts the sweep from any state.
    if (w_accept) w_next = HASH;
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_res_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      HASH: begin
        // Results only belong to this work once the pipe has filled.
        w_res_valid = (r_warm == WARM_MAX);
        w_busy      = 1'b1;
      end
      DRAIN: begin
        w_res_valid = 1'b1;
        w_busy      = 1'b1;
      end
      default: begin
        w_res_valid = 1'b0;
        w_busy      = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operands, latency counters, result attribution
  // ---------------------------------------------------------------------------
  always_ff @(posedge hash_clk) begin
    if (!rst_n) begin
      r_pipe_midstate <= '0;
      r_pipe_data     <= '0;
      r_pipe_nonce    <= '0;
      r_warm          <= '0;
      r_drain         <= '0;
      r_res_nonce     <= '0;
    end else if (w_accept) begin
      // Zeroing warm discards everything still in flight from older work.
      r_pipe_midstate <= bus.work_midstate;
      r_pipe_data     <= bus.work_data;
      r_pipe_nonce    <= '0;
      r_warm          <= '0;
      r_res_nonce     <= '0;
    end else begin
      if (r_state == HASH) begin
        // Holding at NONCE_LAST keeps the nonce from wrapping into DRAIN.
        if (r_pipe_nonce != NONCE_LAST) r_pipe_nonce <= r_pipe_nonce + 32'd1;
        if (r_warm != WARM_MAX)         r_warm       <= r_warm + CNT_ONE;
        r_drain <= '0;
      end else if (r_state == DRAIN) begin
        r_drain <= r_drain + CNT_ONE;
      end
      if (w_res_valid) r_res_nonce <= r_res_nonce + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Golden-nonce queue
  // ---------------------------------------------------------------------------
  assign w_match   = w_res_valid && (hash_tail == GOLDEN_MATCH);
  assign w_pop     = !w_fifo_empty && bus.gn_ready;
  assign w_push_ok = w_match && (!w_fifo_full || w_pop);

  golden_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W)
  ) u_golden_fifo (
    .i_clk   (hash_clk),
    .i_rst_n (rst_n),
    .i_push  (w_match),
    .i_din   (r_res_nonce),
    .i_pop   (bus.gn_ready),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge hash_clk) begin
    if (!rst_n)                                 r_overflow <= 1'b0;
    else if (w_match && w_fifo_full && !w_pop)  r_overflow <= 1'b1;
  end

`ifdef WORK_SCHED_STATS_EN
  logic [47:0] r_hashes_done;
  logic [15:0] r_golden_count;

  always_ff @(posedge hash_clk) begin
    if (!rst_n) begin
      r_hashes_done  <= '0;
      r_golden_count <= '0;
    end else begin
      if (w_res_valid && (r_hashes_done != '1)) r_hashes_done <= r_hashes_done + 48'd1;
      if (w_push_ok) r_golden_count <= r_golden_count + 16'd1;
    end
  end

  assign hashes_done  = r_hashes_done;
  assign golden_count = r_golden_count;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.work_ready = w_ready;
  assign bus.gn_valid   = !w_fifo_empty;
  assign bus.gn_nonce   = w_fifo_dout;
  assign pipe_midstate  = r_pipe_midstate;
  assign pipe_data      = r_pipe_data;
  assign pipe_nonce     = r_pipe_nonce;
  assign busy           = w_busy;
  assign overflow       = r_overflow;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_work_scheduler.sv
// -----------------------------------------------------------------------------
// tb_work_scheduler
// Directed bench for work_scheduler with PIPE_LATENCY=8, NONCE_LAST=31,
// FIFO_DEPTH=4. A behavioural hasher delays {pipe_data, pipe_nonce} by the
// pipe latency and returns the golden word when bit <nonce> of the low 32 data
// bits is set, so each work unit carries its own set of golden nonces.
// Golden pops are checked against an expected queue.
// -----------------------------------------------------------------------------
module tb_work_scheduler;
  import miner_pkg::*;

  localparam int                 PL = 8;
  localparam logic [NONCE_W-1:0] NL = 32'd31;
  localparam int                 FD = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [MIDSTATE_W-1:0] pipe_midstate;
  logic [DATA_W-1:0]     pipe_data;
  logic [NONCE_W-1:0]    pipe_nonce;
  logic [NONCE_W-1:0]    hash_tail = '0;
  logic                  busy;
  logic                  overflow;
  sched_state_t          dbg_state;
`ifdef WORK_SCHED_STATS_EN
  logic [47:0]           hashes_done;
  logic [15:0]           golden_count;
`endif

  work_scheduler_if bus();

  work_scheduler #(
    .PIPE_LATENCY (PL),
    .GOLDEN_MATCH (DEF_GOLDEN_MATCH),
    .NONCE_LAST   (NL),
    .FIFO_DEPTH   (FD)
  ) dut (
    .hash_clk      (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .pipe_midstate (pipe_midstate),
    .pipe_data     (pipe_data),
    .pipe_nonce    (pipe_nonce),
    .hash_tail     (hash_tail),
    .busy          (busy),
    .overflow      (overflow),
`ifdef WORK_SCHED_STATS_EN
    .hashes_done   (hashes_done),
    .golden_count  (golden_count),
`endif
    .o_dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Behavioural hasher: value presented in cycle c comes back in cycle c+PL
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]  sr_d [0:PL];
  logic [NONCE_W-1:0] sr_n [0:PL];

  function automatic logic hasher_hit(input logic [DATA_W-1:0] d, input logic [NONCE_W-1:0] n);
    return (n < 32'd32) && d[n[4:0]];
  endfunction

  initial begin
    for (int i = 0; i <= PL; i++) begin
      sr_d[i] = '0;
      sr_n[i] = '0;
    end
  end

  always @(negedge clk) begin
    for (int i = PL; i > 0; i--) begin
      sr_d[i] = sr_d[i-1];
      sr_n[i] = sr_n[i-1];
    end
    sr_d[0] = pipe_data;
    sr_n[0] = pipe_nonce;
    hash_tail = hasher_hit(sr_d[PL], sr_n[PL]) ? DEF_GOLDEN_MATCH : 32'h0;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int                 n_checks = 0;
  int                 n_fail   = 0;
  logic [NONCE_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every pop the DUT performs must match the oldest expected golden nonce.
  always @(negedge clk) begin
    logic [NONCE_W-1:0] e;
    #1;
    if (bus.gn_valid && bus.gn_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL gn_pop: got unexpected pop of %0h, expected no entry", bus.gn_nonce);
      end else begin
        e = exp_q.pop_front();
        check("gn_pop", 256'(bus.gn_nonce), 256'(e));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all called at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send_work(input logic [DATA_W-1:0] d, input logic [MIDSTATE_W-1:0] m);
    bus.work_valid    = 1'b1;
    bus.work_data     = d;
    bus.work_midstate = m;
    @(negedge clk);
    bus.work_valid    = 1'b0;
    check("accept_nonce", 256'(pipe_nonce), '0);
    check("accept_data",  256'(pipe_data), 256'(d));
    check("accept_mid",   pipe_midstate, m);
    check("accept_state", 256'(dbg_state), 256'(HASH));
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 256'(busy), '0);
  endtask

  // ---------------------------------------------------------------------------
  // Sweep table: cycle offset after accept -> expected nonce / busy / state
  // ---------------------------------------------------------------------------
  typedef struct {
    int                 k;
    logic [NONCE_W-1:0] nonce;
    logic               busy;
    sched_state_t       st;
  } sweep_vec_t;

  sweep_vec_t sweep_tbl [9];

  task automatic run_sweep(input string tag);
    int k = 0;
    for (int i = 0; i < 9; i++) begin
      while (k < sweep_tbl[i].k) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("%s_k%0d_nonce", tag, k), 256'(pipe_nonce), 256'(sweep_tbl[i].nonce));
      check($sformatf("%s_k%0d_busy",  tag, k), 256'(busy),       256'(sweep_tbl[i].busy));
      check($sformatf("%s_k%0d_state", tag, k), 256'(dbg_state),  256'(sweep_tbl[i].st));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    sweep_tbl[0] = '{k: 0,  nonce: 32'd0,  busy: 1'b1, st: HASH};
    sweep_tbl[1] = '{k: 1,  nonce: 32'd1,  busy: 1'b1, st: HASH};
    sweep_tbl[2] = '{k: 8,  nonce: 32'd8,  busy: 1'b1, st: HASH};
    sweep_tbl[3] = '{k: 20, nonce: 32'd20, busy: 1'b1, st: HASH};
    sweep_tbl[4] = '{k: 31, nonce: 32'd31, busy: 1'b1, st: HASH};
    sweep_tbl[5] = '{k: 32, nonce: 32'd31, busy: 1'b1, st: DRAIN};
    sweep_tbl[6] = '{k: 39, nonce: 32'd31, busy: 1'b1, st: DRAIN};
    sweep_tbl[7] = '{k: 40, nonce: 32'd31, busy: 1'b0, st: IDLE};
    sweep_tbl[8] = '{k: 44, nonce: 32'd31, busy: 1'b0, st: IDLE};

    bus.work_valid    = 1'b0;
    bus.work_midstate = '0;
    bus.work_data     = '0;
    bus.gn_ready      = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pipe_nonce", 256'(pipe_nonce), '0);
    check("rst_pipe_data",  256'(pipe_data),  '0);
    check("rst_pipe_mid",   pipe_midstate,    '0);
    check("rst_busy",       256'(busy),       '0);
    check("rst_gn_valid",   256'(bus.gn_valid), '0);
    check("rst_overflow",   256'(overflow),   '0);
    check("rst_state",      256'(dbg_state),  256'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check("work_ready", 256'(bus.work_ready), 256'(1));

    // Plain sweep, no golden tickets
    send_work({64'hAAAA_0001_0000_0001, 32'h0000_0000}, {8{32'h1111_0001}});
    run_sweep("t1");
`ifdef WORK_SCHED_STATS_EN
    check("t1_hashes_done",  256'(hashes_done),  256'(32));
    check("t1_golden_count", 256'(golden_count), '0);
`endif

    // Golden nonces 5 and 31 (31 judged in the last DRAIN cycle)
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd31);
    send_work({64'hAAAA_0002_0000_0002, 32'h8000_0020}, {8{32'h2222_0002}});
    run_sweep("t2");
    check("t2_queue_drained", 256'(exp_q.size()), '0);
`ifdef WORK_SCHED_STATS_EN
    check("t2_hashes_done",  256'(hashes_done),  256'(64));
    check("t2_golden_count", 256'(golden_count), 256'(2));
`endif

    // New work mid-HASH: old nonces 13..20 are in flight and must be lost.
    // Work A's nonce 3 and work B's nonce 2 are the only survivors.
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd2);
    send_work({64'hAAAA_0003_0000_0003, 32'h001F_E008}, {8{32'h3333_0003}});
    repeat (20) @(negedge clk);
    check("t3_nonce20", 256'(pipe_nonce), 256'(20));
    send_work({64'hAAAA_0004_0000_0004, 32'h0000_0004}, {8{32'h4444_0004}});
    wait_idle("t3", 100);
    repeat (3) @(negedge clk);
    check("t3_queue_drained", 256'(exp_q.size()), '0);

    // Six goldens with nobody popping: four held, two dropped
    bus.gn_ready = 1'b0;
    send_work({64'hAAAA_0005_0000_0005, 32'h4000_0652}, {8{32'h5555_0005}});
    wait_idle("t4", 100);
    check("t4_overflow", 256'(overflow),     256'(1));
    check("t4_gn_valid", 256'(bus.gn_valid), 256'(1));
    check("t4_head",     256'(bus.gn_nonce), 256'(1));
    repeat (3) @(negedge clk);
    check("t4_head_stable", 256'(bus.gn_nonce), 256'(1));
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd9);
    bus.gn_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("t4_queue_drained", 256'(exp_q.size()), '0);
    check("t4_gn_valid_low",  256'(bus.gn_valid), '0);
    check("t4_overflow_sticky", 256'(overflow),   256'(1));

    // Reset mid-HASH with a queued golden: everything clears, nothing pops
    bus.gn_ready = 1'b0;
    send_work({64'hAAAA_0006_0000_0006, 32'h0000_0002}, {8{32'h6666_0006}});
    repeat (15) @(negedge clk);
    check("t5_gn_valid_pre", 256'(bus.gn_valid), 256'(1));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_busy",       256'(busy),         '0);
    check("t5_gn_valid",   256'(bus.gn_valid), '0);
    check("t5_overflow",   256'(overflow),     '0);
    check("t5_pipe_nonce", 256'(pipe_nonce),   '0);
    check("t5_pipe_data",  256'(pipe_data),    '0);
    check("t5_state",      256'(dbg_state),    256'(IDLE));
    rst_n = 1'b1;
    bus.gn_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_work_ready",  256'(bus.work_ready), 256'(1));
    check("t5_gn_valid_post", 256'(bus.gn_valid), '0);

    // Push into a full queue in the same cycle as a pop is accepted
    bus.gn_ready = 1'b0;
    for (int n = 0; n < 5; n++) exp_q.push_back(32'(n));
    send_work({64'hAAAA_0007_0000_0007, 32'h0000_001F}, {8{32'h7777_0007}});
    repeat (12) @(negedge clk);
    check("t6_gn_valid", 256'(bus.gn_valid), 256'(1));
    bus.gn_ready = 1'b1;
    wait_idle("t6", 100);
    repeat (3) @(negedge clk);
    check("t6_queue_drained", 256'(exp_q.size()), '0);
    check("t6_overflow",      256'(overflow),     '0);

    check("final_queue_empty", 256'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
